outfifo_readout_ctrl: RTL

Read-side sequencer for the 48-bit DAQ output FIFO. It drains the FIFO in frames and wraps each frame as header, body words, then trailer. The trailer carries an event count, a word count, a checksum and error flags. It presents frames to the downstream DAQ link over a valid/ready handshake and forwards the FIFO half-full flag as a registered throttle.

---
 rtl/outfifo_readout_ctrl_if.sv | 20 ++
 rtl/outfifo_readout_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/outfifo_readout_ctrl_if.sv
// Bundle of the FIFO read port and the DAQ link valid/ready port.
// The master side is the readout controller; the slave side is the environment.
interface outfifo_readout_ctrl_if;
   logic [47:0] fifo_dout;
   logic        fifo_empty;
   logic        fifo_rden;
   logic [47:0] out_data;
   logic        out_valid;
   logic        out_ready;

   modport master (
      input  fifo_dout, fifo_empty, out_ready,
      output fifo_rden, out_data, out_valid
   );

   modport slave (
      output fifo_dout, fifo_empty, out_ready,
      input  fifo_rden, out_data, out_valid
   );
endinterface

// File: rtl/outfifo_readout_ctrl.sv
// Read-side sequencer for the 48-bit DAQ output FIFO.
// Each frame goes out as header, body words (bit 47 marks the last), trailer.
// Body words pass through a 2-entry skid buffer whose head drives out_data.
// A read is only issued with no other read in flight: the in-flight word may
// be the frame marker, and reading past it would pull the next frame's data.
module outfifo_readout_ctrl #(
   parameter int         TIMEOUT  = 256,
   parameter logic [7:0] HDR_MARK = 8'hA5,
   parameter logic [7:0] TRL_MARK = 8'h5A
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic no_space_for_daq,
   output logic daq_throttle,
   output logic busy,
   outfifo_readout_ctrl_if.master bus
);

   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_HEADER, S_BODY, S_TRAILER} state_t;

   state_t        r_state;
   state_t        w_state_next;
   logic [47:0]   r_buf [0:1];
   logic [47:0]   w_buf_next [0:1];
   logic [1:0]    r_cnt;
   logic [1:0]    w_cnt_mid;
   logic [1:0]    w_cnt_next;
   logic          r_rd_pend;
   logic          r_mark_in;
   logic [11:0]   r_evt_cnt;
   logic [11:0]   r_word_cnt;
   logic [23:0]   r_chk;
   logic [TW-1:0] r_tmo_cnt;
   logic          r_tmo;
   logic          r_ovf;
   logic          r_throttle;

   logic          w_pop;
   logic          w_push;
   logic          w_rden;
   logic          w_tmo_inc;
   logic          w_tmo_hit;
   logic          w_valid;
   logic [47:0]   w_data;

   assign w_pop     = (r_state == S_BODY) && (r_cnt != 2'd0) && bus.out_ready;
   assign w_push    = r_rd_pend;
   assign w_rden    = (r_state == S_BODY) && !bus.fifo_empty && !r_mark_in && !r_rd_pend
                      && ((r_cnt - 2'(w_pop)) < 2'd2);
   assign w_tmo_inc = (r_state == S_BODY) && bus.fifo_empty && (r_cnt == 2'd0) && !r_rd_pend;
   assign w_tmo_hit = w_tmo_inc && (r_tmo_cnt == TW'(TIMEOUT - 1));

   assign bus.fifo_rden = w_rden;
   assign bus.out_valid = w_valid;
   assign bus.out_data  = w_data;
   assign busy          = (r_state != S_IDLE);
   assign daq_throttle  = r_throttle;

   // Next state and frame-word selection; out_data is zero whenever nothing is offered.
   always_comb begin
      w_state_next = r_state;
      w_valid      = 1'b0;
      w_data       = '0;
      case (r_state)
         S_IDLE: begin
            if (en && !bus.fifo_empty) w_state_next = S_HEADER;
         end
         S_HEADER: begin
            w_valid = 1'b1;
            w_data  = {HDR_MARK, r_evt_cnt, 28'd0};
            if (bus.out_ready) w_state_next = S_BODY;
         end
         S_BODY: begin
            if (r_cnt != 2'd0) begin
               w_valid = 1'b1;
               w_data  = r_buf[0];
            end
            if (w_pop && r_buf[0][47]) w_state_next = S_TRAILER;
            else if (w_tmo_hit)        w_state_next = S_TRAILER;
         end
         S_TRAILER: begin
            w_valid = 1'b1;
            w_data  = {TRL_MARK, r_tmo, r_ovf, 2'b00, r_word_cnt, r_chk};
            if (bus.out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Skid buffer update: pop shifts the head out, the returning FIFO word lands behind what remains.
   always_comb begin
      w_buf_next[0] = r_buf[0];
      w_buf_next[1] = r_buf[1];
      w_cnt_mid     = r_cnt;
      if (w_pop) begin
         w_buf_next[0] = r_buf[1];
         w_cnt_mid     = r_cnt - 2'd1;
      end
      w_cnt_next = w_cnt_mid;
      if (w_push) begin
         if (w_cnt_mid == 2'd0) w_buf_next[0] = bus.fifo_dout;
         else                   w_buf_next[1] = bus.fifo_dout;
         w_cnt_next = w_cnt_mid + 2'd1;
      end
   end

   // Skid buffer storage, emptied on reset.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_buf
         always_ff @(posedge clk) begin
            if (rst) r_buf[gi] <= '0;
            else     r_buf[gi] <= w_buf_next[gi];
         end
      end
   endgenerate

   // Sequencer state, frame counters, checksum and timeout tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= 2'd0;
         r_rd_pend  <= 1'b0;
         r_mark_in  <= 1'b0;
         r_evt_cnt  <= 12'd0;
         r_word_cnt <= 12'd0;
         r_chk      <= 24'd0;
         r_tmo_cnt  <= '0;
         r_tmo      <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_rd_pend <= w_rden;
         if ((r_state == S_HEADER) && bus.out_ready) begin
            r_word_cnt <= 12'd0;
            r_chk      <= 24'd0;
            r_tmo_cnt  <= '0;
            r_mark_in  <= 1'b0;
         end
         if (w_push && bus.fifo_dout[47]) r_mark_in <= 1'b1;
         if (w_pop) begin
            if (r_word_cnt == 12'hFFF) r_ovf <= 1'b1;
            else                       r_word_cnt <= r_word_cnt + 12'd1;
            r_chk <= r_chk ^ r_buf[0][47:24] ^ r_buf[0][23:0];
         end
         if (w_push)         r_tmo_cnt <= '0;
         else if (w_tmo_inc) r_tmo_cnt <= r_tmo_cnt + TW'(1);
         if (w_tmo_hit) r_tmo <= 1'b1;
         if ((r_state == S_TRAILER) && bus.out_ready) begin
            r_evt_cnt <= r_evt_cnt + 12'd1;
            r_tmo     <= 1'b0;
            r_ovf     <= 1'b0;
         end
      end
   end

   // FIFO half-full flag delayed by one clock toward the DAQ link.
   always_ff @(posedge clk) begin
      if (rst) r_throttle <= 1'b0;
      else     r_throttle <= no_space_for_daq;
   end

endmodule
